// File: rtl/ibex_pkg.sv
// Shared types and sizing helpers for the register-file snapshot streamer.
package ibex_pkg;

  typedef enum logic [1:0] {
    SNAP_IDLE,
    SNAP_SCAN,
    SNAP_DONE
  } snap_state_e;

  // Architectural register count: RV32E has 16 registers, RV32I has 32.
  function automatic int unsigned num_words(input bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

endpackage

// File: rtl/ibex_rf_snap_ffs.sv
// Find-first-set over the pending mask: lowest set index, any-set and single-bit flags.
module ibex_rf_snap_ffs #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] mask_i,
  output logic [4:0]       idx_o,
  output logic             any_o,
  output logic             single_o
);

  localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

  // Descending scan so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = i[4:0];
    end
  end

  assign any_o    = |mask_i;
  assign single_o = any_o && ((mask_i & (mask_i - One)) == '0);

endmodule

// File: rtl/ibex_rf_snapshot_streamer.sv
// Captures the architectural register array on request and streams it one register
// per beat over valid/ready, optionally only the registers changed since the last snapshot.
module ibex_rf_snapshot_streamer
  import ibex_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter bit          DeltaOnly = 1'b1,
  localparam int unsigned NumWords = num_words(RV32E)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumWords-1:0][DataWidth-1:0] regfile_i,
  input  logic                               snap_req_i,
  output logic                               snap_busy_o,
  output logic                               snap_drop_o,
  output logic                               snap_done_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [4:0]                         out_idx_o,
  output logic [DataWidth-1:0]               out_data_o,
  output logic                               out_last_o
);

  localparam int unsigned IdxW = $clog2(NumWords);

  snap_state_e                        state_q;
  logic [NumWords-1:0][DataWidth-1:0] snap_q, prev_q, snap_d;
  logic [NumWords-1:0]                pend_q, pend_d, pend_init;
  logic [4:0]                         ffs_idx;
  logic                               ffs_any, ffs_single;
  logic                               in_scan, handshake;

  ibex_rf_snap_ffs #(
    .Width(NumWords)
  ) u_ffs (
    .mask_i  (pend_q),
    .idx_o   (ffs_idx),
    .any_o   (ffs_any),
    .single_o(ffs_single)
  );

  // x0 is hard-wired zero, so it is never captured and never marked pending.
  always_comb begin
    snap_d    = regfile_i;
    snap_d[0] = '0;
    pend_init = '0;
    for (int i = 1; i < NumWords; i++) begin
      pend_init[i] = DeltaOnly ? (regfile_i[i] != prev_q[i]) : 1'b1;
    end
  end

  assign in_scan   = (state_q == SNAP_SCAN);
  assign handshake = out_valid_o && out_ready_i;
  // Retiring a beat clears the lowest set bit, which is the one being presented.
  assign pend_d    = handshake ? (pend_q & (pend_q - {{(NumWords-1){1'b0}}, 1'b1})) : pend_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SNAP_IDLE;
      snap_q  <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
    end else begin
      case (state_q)
        SNAP_IDLE: begin
          if (snap_req_i) begin
            snap_q  <= snap_d;
            pend_q  <= pend_init;
            state_q <= SNAP_SCAN;
          end
        end
        SNAP_SCAN: begin
          pend_q <= pend_d;
          if (pend_d == '0) state_q <= SNAP_DONE;
        end
        SNAP_DONE: begin
          prev_q  <= snap_q;
          state_q <= SNAP_IDLE;
        end
        default: state_q <= SNAP_IDLE;
      endcase
    end
  end

  assign snap_busy_o = (state_q != SNAP_IDLE);
  assign snap_drop_o = snap_req_i && snap_busy_o;
  assign snap_done_o = (state_q == SNAP_DONE);
  assign out_valid_o = in_scan && ffs_any;
  assign out_idx_o   = ffs_idx;
  assign out_data_o  = snap_q[ffs_idx[IdxW-1:0]];
  assign out_last_o  = in_scan && ffs_single;

endmodule

// File: tb/tb_ibex_rf_snapshot_streamer.sv
// Randomized bench for the snapshot streamer: an RV32I delta instance and an RV32E full instance.
module tb_ibex_rf_snapshot_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [31:0][31:0] rf_a;
  logic [15:0][31:0] rf_b;
  logic              req_a, req_b, rdy_a, rdy_b;
  logic              busy_a, drop_a, done_a, vld_a, last_a;
  logic              busy_b, drop_b, done_b, vld_b, last_b;
  logic [4:0]        idx_a, idx_b;
  logic [31:0]       dat_a, dat_b;

  ibex_rf_snapshot_streamer #(.RV32E(1'b0), .DataWidth(32), .DeltaOnly(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .regfile_i(rf_a), .snap_req_i(req_a),
    .snap_busy_o(busy_a), .snap_drop_o(drop_a), .snap_done_o(done_a),
    .out_valid_o(vld_a), .out_ready_i(rdy_a), .out_idx_o(idx_a),
    .out_data_o(dat_a), .out_last_o(last_a)
  );

  ibex_rf_snapshot_streamer #(.RV32E(1'b1), .DataWidth(32), .DeltaOnly(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .regfile_i(rf_b), .snap_req_i(req_b),
    .snap_busy_o(busy_b), .snap_drop_o(drop_b), .snap_done_o(done_b),
    .out_valid_o(vld_b), .out_ready_i(rdy_b), .out_idx_o(idx_b),
    .out_data_o(dat_b), .out_last_o(last_b)
  );

  int          sel_g;
  logic        busy, drop, done, vld, last;
  logic [4:0]  idx;
  logic [31:0] dat;

  assign busy = (sel_g == 1) ? busy_b : busy_a;
  assign drop = (sel_g == 1) ? drop_b : drop_a;
  assign done = (sel_g == 1) ? done_b : done_a;
  assign vld  = (sel_g == 1) ? vld_b  : vld_a;
  assign last = (sel_g == 1) ? last_b : last_a;
  assign idx  = (sel_g == 1) ? idx_b  : idx_a;
  assign dat  = (sel_g == 1) ? dat_b  : dat_a;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] cur  [32];
  logic [31:0] prev [2][32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_req(input int sel, input logic v);
    if (sel == 1) req_b = v; else req_a = v;
  endtask

  task automatic set_rdy(input int sel, input logic v);
    if (sel == 1) rdy_b = v; else rdy_a = v;
  endtask

  // mode: 0 ready always high, 1 random ready, 2 ready low for the first 3 scan cycles.
  task automatic run_snap(input int sel, input int mode, input bit do_drop, input int abort_at);
    int          n;
    bit          dl;
    int          q_idx[$];
    logic [31:0] q_dat[$];
    int          k, drop_c;
    bit          done_seen, rdy, exp_v;
    sel_g = sel;
    n     = (sel == 1) ? 16 : 32;
    dl    = (sel == 0);
    for (int i = 1; i < n; i++) begin
      if (!dl || cur[i] !== prev[sel][i]) begin
        q_idx.push_back(i);
        q_dat.push_back(cur[i]);
      end
    end
    k      = q_idx.size();
    drop_c = do_drop ? int'($urandom_range(0, k)) : -1;
    for (int i = 0; i < n; i++) begin
      if (sel == 1) rf_b[i] = cur[i]; else rf_a[i] = cur[i];
    end
    set_req(sel, 1'b1);
    @(negedge clk);
    set_req(sel, 1'b0);
    // Live array changes after capture must not leak into the stream.
    for (int i = 0; i < n; i++) begin
      if (sel == 1) rf_b[i] = $urandom; else rf_a[i] = $urandom;
    end
    done_seen = 1'b0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      set_req(sel, 1'b0);
      #1;
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_valid", vld, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
          prev[0][i] = '0;
          prev[1][i] = '0;
        end
        set_rdy(sel, 1'b1);
        return;
      end
      exp_v = (q_idx.size() > 0);
      if (exp_v) begin
        chk("beat_valid", vld, 1'b1);
        chk("beat_idx", idx, q_idx[0]);
        chk("beat_data", dat, q_dat[0]);
        chk("beat_last", last, q_idx.size() == 1);
        chk("beat_done", done, 1'b0);
        chk("beat_busy", busy, 1'b1);
      end else if (k == 0 && c == 0) begin
        chk("empty_valid", vld, 1'b0);
        chk("empty_done", done, 1'b0);
        chk("empty_busy", busy, 1'b1);
      end else begin
        chk("done_pulse", done, 1'b1);
        chk("done_valid", vld, 1'b0);
        chk("done_busy", busy, 1'b1);
        done_seen = 1'b1;
      end
      chk("drop_quiet", drop, 1'b0);
      rdy = (mode == 0) ? 1'b1 : (mode == 2) ? (c >= 3) : 1'($urandom_range(0, 1));
      set_rdy(sel, rdy);
      if (c == drop_c) begin
        set_req(sel, 1'b1);
        #1;
        chk("drop_pulse", drop, 1'b1);
      end
      if (exp_v && rdy) begin
        void'(q_idx.pop_front());
        void'(q_dat.pop_front());
      end
      if (!done_seen) @(negedge clk);
    end
    if (!done_seen) chk("done_timeout", 1'b0, 1'b1);
    @(negedge clk);
    set_req(sel, 1'b0);
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_valid", vld, 1'b0);
    for (int i = 1; i < n; i++) prev[sel][i] = cur[i];
    set_rdy(sel, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    rf_a  = '0;   rf_b  = '0;   sel_g = 0;
    for (int i = 0; i < 32; i++) begin
      cur[i] = '0; prev[0][i] = '0; prev[1][i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_valid_a", vld_a, 1'b0);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_done_a", done_a, 1'b0);
    chk("rst_drop_a", drop_a, 1'b0);
    chk("rst_idx_a", idx_a, 5'd0);
    chk("rst_data_a", dat_a, 32'd0);
    chk("rst_last_a", last_a, 1'b0);
    chk("rst_valid_b", vld_b, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    rst_n = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1;
    @(negedge clk);

    cur[0] = 32'hdead_beef;
    cur[1] = 32'd5;
    cur[3] = 32'd7;
    run_snap(0, 0, 1'b0, -1);
    run_snap(0, 0, 1'b0, -1);
    cur[3] = 32'd9;
    run_snap(0, 2, 1'b0, -1);
    cur[5] = 32'd11; cur[6] = 32'd12; cur[7] = 32'd13;
    run_snap(0, 0, 1'b1, -1);

    for (int i = 0; i < 16; i++) cur[i] = $urandom;
    run_snap(1, 0, 1'b0, -1);

    for (int i = 0; i < 32; i++) cur[i] = 32'h1000 + i;
    run_snap(0, 0, 1'b0, 2);
    for (int i = 0; i < 32; i++) cur[i] = '0;
    cur[1] = 32'd5;
    run_snap(0, 0, 1'b0, -1);

    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 3) == 0) cur[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      end
      run_snap(int'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
